clock_receive_monitor: RTL and testbench

Receive-side checker for one divided clock produced by the RCD clock distribution network. It samples the returned clock as asynchronous data in the `ref_clk` domain and measures each period and high time in `ref_clk` cycles. It compares both against the configured divide ratio, acquires and declares lock, and reports frequency, duty-cycle and loss-of-clock faults as sticky status for the config/I3C block.

---
 rtl/clock_receive_monitor.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_clock_receive_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_receive_monitor.sv
// ---------------------------------------------------------------------------
// clock_receive_monitor
//
// Receive-side checker for one divided clock of the RCD clock distribution
// network.  The returned clock is sampled as plain data in the ref_clk
// domain, each period and high time is measured in ref_clk cycles and
// compared against the configured divide ratio.  The block acquires lock,
// then reports frequency, duty-cycle and loss-of-clock faults as sticky
// status flags.
//
// Optional feature macro: CLK_MON_DUTY_CHECK_EN
//    defined     : high time is measured and checked (duty_error live)
//    not defined : high-time counter removed, meas_high/duty_error tied 0
//
// Ports
//    ref_clk        in   sole clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    cfg_enable     in   monitor enable
//    cfg_div_ratio  in   expected divide ratio N (valid 2..15)
//    err_clr        in   single-cycle pulse clearing the sticky flags
//    mon_clk_in     in   monitored clock (asynchronous, sampled as data)
//    meas_valid     out  one-cycle pulse, new measurement present
//    meas_period    out  last measured period
//    meas_high      out  last measured high time
//    clk_locked     out  high while in LOCKED
//    clk_lost       out  sticky loss-of-clock flag
//    freq_error     out  sticky period-violation flag
//    duty_error     out  sticky high-time-violation flag
//    error_code     out  {cfg_err, 4'b0, clk_lost, duty_error, freq_error}
//    err_count      out  saturating fault event count
//    mon_state      out  IDLE=0 ARM=1 TRACK=2 LOCKED=3 FAULT=4
// ---------------------------------------------------------------------------
module clock_receive_monitor #(
   parameter int CNT_W        = 8,
   parameter int TOL          = 1,
   parameter int LOCK_COUNT   = 4,
   parameter int LOSS_TIMEOUT = 64
) (
   input  logic             ref_clk,
   input  logic             rst_n,
   input  logic             cfg_enable,
   input  logic [3:0]       cfg_div_ratio,
   input  logic             err_clr,
   input  logic             mon_clk_in,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_period,
   output logic [CNT_W-1:0] meas_high,
   output logic             clk_locked,
   output logic             clk_lost,
   output logic             freq_error,
   output logic             duty_error,
   output logic [7:0]       error_code,
   output logic [15:0]      err_count,
   output logic [2:0]       mon_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_TRACK  = 3'd2,
      S_LOCKED = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_TIMEOUT - 1);
   localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_COUNT - 1);
   localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

   state_t state, state_next;

   logic sync1, sync2, dly, rise;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] cur_period;
   logic [GW-1:0]    good_cnt, good_next;
   logic [3:0]       ratio_snap;
   logic             loss_hold;
   logic             cfg_err;
   logic             ratio_chg;
   logic             loss_evt;
   logic             counters_clr;
   logic             per_ok, high_ok, meas_good;
   logic             capture, snap_load, lost_set, count_evt;
   logic             set_freq, set_duty;
   logic [CNT_W:0]   ratio_ext;
   logic signed [CNT_W:0] per_diff, per_abs;

   assign rise         = sync2 & ~dly;
   assign cfg_err      = cfg_enable && (cfg_div_ratio < 4'd2);
   assign ratio_chg    = (cfg_div_ratio != ratio_snap);
   assign counters_clr = !cfg_enable || (state == S_IDLE);
   assign loss_evt     = (state != S_IDLE) && !loss_hold && !rise && (pcnt == LOSS_LAST);
   assign cur_period   = (pcnt == CNT_MAX) ? CNT_MAX : pcnt + 1'b1;
   assign ratio_ext    = {{(CNT_W-3){1'b0}}, cfg_div_ratio};

   // Two-flop synchronizer for the asynchronous monitored clock, followed by
   // a delay register so a rising edge shows up as a one-cycle rise strobe.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= mon_clk_in;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   // Period counter: free-running and saturating, restarted by every rise.
   // It is held at zero in IDLE so a fresh ARM always starts its loss
   // timeout from a clean count.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (counters_clr || rise) begin
         pcnt <= '0;
      end else if (pcnt != CNT_MAX) begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Period check: |period - N| <= TOL evaluated signed, one bit wider than
   // the counters so the subtraction cannot wrap.
   always_comb begin
      per_diff = $signed({1'b0, cur_period}) - $signed(ratio_ext);
      per_abs  = per_diff[CNT_W] ? -per_diff : per_diff;
      per_ok   = (per_abs <= TOL_S);
   end

`ifdef CLK_MON_DUTY_CHECK_EN
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] meas_high_q;
   logic             duty_q;
   logic [CNT_W:0]   half_ext;
   logic signed [CNT_W:0] high_diff, high_abs;

   // High-time counter: counts cycles with the synchronized level high.
   // The rise cycle is itself high, so the restart value is 1.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
      end else if (counters_clr) begin
         hcnt <= '0;
      end else if (rise) begin
         hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (sync2 && (hcnt != CNT_MAX)) begin
         hcnt <= hcnt + 1'b1;
      end
   end

   // High-time check against N/2 with the same tolerance as the period.
   always_comb begin
      half_ext  = {{(CNT_W-2){1'b0}}, cfg_div_ratio[3:1]};
      high_diff = $signed({1'b0, hcnt}) - $signed(half_ext);
      high_abs  = high_diff[CNT_W] ? -high_diff : high_diff;
      high_ok   = (high_abs <= TOL_S);
   end

   // Captured high time and sticky duty flag; a new violation beats err_clr.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_high_q <= '0;
         duty_q      <= 1'b0;
      end else begin
         if (capture) begin
            meas_high_q <= hcnt;
         end
         if (!cfg_enable) begin
            duty_q <= 1'b0;
         end else begin
            duty_q <= set_duty | (duty_q & ~err_clr);
         end
      end
   end

   assign meas_high  = meas_high_q;
   assign duty_error = duty_q;
`else
   assign high_ok    = 1'b1;
   assign meas_high  = '0;
   assign duty_error = 1'b0;
`endif

   assign meas_good = per_ok && high_ok;

   // Next-state logic.  Disable and bad configuration dominate, then the
   // IDLE exit, then a ratio change, then loss of clock; measurements are
   // only judged on cycles where a rise is seen and nothing above fired.
   always_comb begin
      state_next = state;
      good_next  = good_cnt;
      capture    = 1'b0;
      snap_load  = 1'b0;
      lost_set   = 1'b0;
      count_evt  = 1'b0;
      set_freq   = 1'b0;
      set_duty   = 1'b0;
      if (!cfg_enable || cfg_err) begin
         state_next = S_IDLE;
         good_next  = '0;
      end else if (state == S_IDLE) begin
         state_next = S_ARM;
         good_next  = '0;
         snap_load  = 1'b1;
      end else if (ratio_chg) begin
         state_next = S_ARM;
         good_next  = '0;
         snap_load  = 1'b1;
      end else if (loss_evt) begin
         state_next = S_ARM;
         good_next  = '0;
         lost_set   = 1'b1;
         count_evt  = 1'b1;
      end else if (rise) begin
         case (state)
            S_ARM: begin
               state_next = S_TRACK;
               good_next  = '0;
            end
            S_TRACK, S_FAULT: begin
               capture = 1'b1;
               if (!meas_good) begin
                  good_next = '0;
               end else if (good_cnt == LOCK_LAST) begin
                  state_next = S_LOCKED;
                  good_next  = '0;
               end else begin
                  good_next = good_cnt + 1'b1;
               end
            end
            S_LOCKED: begin
               capture = 1'b1;
               if (!meas_good) begin
                  state_next = S_FAULT;
                  good_next  = '0;
                  set_freq   = !per_ok;
                  set_duty   = !high_ok;
                  count_evt  = 1'b1;
               end
            end
            default: begin
               state_next = S_IDLE;
               good_next  = '0;
            end
         endcase
      end
   end

   // State register plus the bookkeeping that follows it: ratio snapshot,
   // loss re-arm latch and consecutive-good counter.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         good_cnt   <= '0;
         ratio_snap <= '0;
         loss_hold  <= 1'b0;
      end else begin
         state    <= state_next;
         good_cnt <= good_next;
         if (snap_load) begin
            ratio_snap <= cfg_div_ratio;
         end
         if (counters_clr || rise) begin
            loss_hold <= 1'b0;
         end else if (lost_set) begin
            loss_hold <= 1'b1;
         end
      end
   end

   // Measurement outputs, sticky flags and the saturating event counter.
   // The event counter survives a disable; only reset clears it.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_valid  <= 1'b0;
         meas_period <= '0;
         clk_lost    <= 1'b0;
         freq_error  <= 1'b0;
         err_count   <= '0;
      end else begin
         meas_valid <= capture;
         if (capture) begin
            meas_period <= cur_period;
         end
         if (!cfg_enable) begin
            clk_lost   <= 1'b0;
            freq_error <= 1'b0;
         end else begin
            clk_lost   <= lost_set | (clk_lost & ~err_clr);
            freq_error <= set_freq | (freq_error & ~err_clr);
         end
         if (count_evt && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
         end
      end
   end

   assign clk_locked = (state == S_LOCKED);
   assign mon_state  = state;
   assign error_code = {cfg_err, 4'b0000, clk_lost, duty_error, freq_error};

endmodule

// File: tb/tb_clock_receive_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_receive_monitor
//
// Directed bench for clock_receive_monitor with default parameters
// (CNT_W=8, TOL=1, LOCK_COUNT=4, LOSS_TIMEOUT=64).  The monitored clock is
// generated as whole ref_clk cycles high/low; inputs change 1 time unit after
// a rising ref_clk edge and outputs are read at that same offset.
// Works with or without CLK_MON_DUTY_CHECK_EN defined.
// ---------------------------------------------------------------------------
module tb_clock_receive_monitor;

`ifdef CLK_MON_DUTY_CHECK_EN
   localparam bit DUTY_ON = 1'b1;
`else
   localparam bit DUTY_ON = 1'b0;
`endif

   logic        ref_clk;
   logic        rst_n;
   logic        cfg_enable;
   logic [3:0]  cfg_div_ratio;
   logic        err_clr;
   logic        mon_clk_in;
   logic        meas_valid;
   logic [7:0]  meas_period;
   logic [7:0]  meas_high;
   logic        clk_locked;
   logic        clk_lost;
   logic        freq_error;
   logic        duty_error;
   logic [7:0]  error_code;
   logic [15:0] err_count;
   logic [2:0]  mon_state;

   int total = 0;
   int bad   = 0;
   int valid_count = 0;
   logic locked_at_valid = 1'b0;
   int vc0;
   int loss_n;

   clock_receive_monitor dut (
      .ref_clk       (ref_clk),
      .rst_n         (rst_n),
      .cfg_enable    (cfg_enable),
      .cfg_div_ratio (cfg_div_ratio),
      .err_clr       (err_clr),
      .mon_clk_in    (mon_clk_in),
      .meas_valid    (meas_valid),
      .meas_period   (meas_period),
      .meas_high     (meas_high),
      .clk_locked    (clk_locked),
      .clk_lost      (clk_lost),
      .freq_error    (freq_error),
      .duty_error    (duty_error),
      .error_code    (error_code),
      .err_count     (err_count),
      .mon_state     (mon_state)
   );

   // Free-running reference clock, rising edges at 5, 15, 25, ...
   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   // Counts measurement pulses and records the lock flag seen alongside
   // each one, sampled on the falling edge.
   always @(negedge ref_clk) begin
      if (meas_valid === 1'b1) begin
         valid_count = valid_count + 1;
         locked_at_valid = clk_locked;
      end
   end

   task automatic applyStimulus(input int n);
      repeat (n) @(posedge ref_clk);
      #1;
   endtask

   task automatic monPeriod(input int hi, input int lo);
      mon_clk_in = 1'b1;
      applyStimulus(hi);
      mon_clk_in = 1'b0;
      applyStimulus(lo);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      cfg_enable    = 1'b0;
      cfg_div_ratio = 4'd4;
      err_clr       = 1'b0;
      mon_clk_in    = 1'b0;

      // Reset state
      applyStimulus(2);
      checkOutput("rst_state",  32'(mon_state),   32'd0);
      checkOutput("rst_code",   32'(error_code),  32'h00);
      checkOutput("rst_count",  32'(err_count),   32'd0);
      checkOutput("rst_valid",  32'(meas_valid),  32'd0);
      checkOutput("rst_locked", 32'(clk_locked),  32'd0);
      rst_n = 1'b1;
      applyStimulus(2);

      // N=4, 2 high / 2 low: lock at the 4th measurement (5th rise)
      $display("[TB] lock acquisition N=4");
      vc0 = valid_count;
      cfg_enable = 1'b1;
      repeat (4) monPeriod(2, 2);
      checkOutput("acq_valid3",  32'(valid_count - vc0), 32'd3);
      checkOutput("acq_nolock",  32'(clk_locked),  32'd0);
      checkOutput("acq_track",   32'(mon_state),   32'd2);
      monPeriod(2, 2);
      checkOutput("acq_valid4",  32'(valid_count - vc0), 32'd4);
      checkOutput("acq_lockpls", 32'(locked_at_valid), 32'd1);
      checkOutput("acq_locked",  32'(clk_locked),  32'd1);
      checkOutput("acq_period",  32'(meas_period), 32'd4);
      checkOutput("acq_high",    32'(meas_high),   DUTY_ON ? 32'd2 : 32'd0);
      checkOutput("acq_code",    32'(error_code),  32'h00);
      checkOutput("acq_pulse",   32'(meas_valid),  32'd0);

      // Stretch one period to 6 while locked
      $display("[TB] frequency fault");
      monPeriod(2, 4);
      monPeriod(2, 2);
      checkOutput("frq_period", 32'(meas_period), 32'd6);
      checkOutput("frq_code",   32'(error_code),  32'h01);
      checkOutput("frq_state",  32'(mon_state),   32'd4);
      checkOutput("frq_count",  32'(err_count),   32'd1);
      repeat (3) monPeriod(2, 2);
      checkOutput("frq_still",  32'(mon_state),   32'd4);
      monPeriod(2, 2);
      checkOutput("frq_relock", 32'(mon_state),   32'd3);
      checkOutput("frq_sticky", 32'(error_code),  32'h01);
      err_clr = 1'b1;
      applyStimulus(1);
      err_clr = 1'b0;
      checkOutput("frq_clr",    32'(error_code),  32'h00);

      // Hold input low: loss flagged 64 edges after the last pcnt clear
      $display("[TB] loss of clock");
      monPeriod(2, 2);
      loss_n = -1;
      for (int n = 1; n <= 200; n++) begin
         applyStimulus(1);
         if (clk_lost === 1'b1) begin
            loss_n = n;
            break;
         end
      end
      checkOutput("los_delay",  32'(loss_n),      32'd63);
      checkOutput("los_code",   32'(error_code),  32'h04);
      checkOutput("los_state",  32'(mon_state),   32'd1);
      checkOutput("los_count",  32'(err_count),   32'd2);
      applyStimulus(100);
      checkOutput("los_once",   32'(err_count),   32'd2);
      vc0 = valid_count;
      repeat (4) monPeriod(2, 2);
      checkOutput("los_nolock", 32'(clk_locked),  32'd0);
      monPeriod(2, 2);
      checkOutput("los_relock", 32'(clk_locked),  32'd1);
      checkOutput("los_valids", 32'(valid_count - vc0), 32'd4);
      checkOutput("los_sticky", 32'(error_code),  32'h04);

      // Disable clears flags but keeps the event count
      cfg_enable = 1'b0;
      applyStimulus(1);
      checkOutput("dis_state",  32'(mon_state),   32'd0);
      checkOutput("dis_code",   32'(error_code),  32'h00);
      checkOutput("dis_count",  32'(err_count),   32'd2);

      // N=8: lock on 4/4, then 6/2 high time
      $display("[TB] duty check N=8");
      cfg_div_ratio = 4'd8;
      cfg_enable    = 1'b1;
      repeat (5) monPeriod(4, 4);
      checkOutput("dut_locked", 32'(clk_locked),  32'd1);
      checkOutput("dut_high4",  32'(meas_high),   DUTY_ON ? 32'd4 : 32'd0);
      repeat (2) monPeriod(6, 2);
      checkOutput("dut_period", 32'(meas_period), 32'd8);
      checkOutput("dut_high6",  32'(meas_high),   DUTY_ON ? 32'd6 : 32'd0);
      checkOutput("dut_code",   32'(error_code),  DUTY_ON ? 32'h02 : 32'h00);
      checkOutput("dut_state",  32'(mon_state),   DUTY_ON ? 32'd4 : 32'd3);
      checkOutput("dut_count",  32'(err_count),   DUTY_ON ? 32'd3 : 32'd2);

      // Ratio change while running: back to ARM, no new error
      cfg_div_ratio = 4'd4;
      applyStimulus(1);
      checkOutput("chg_state",  32'(mon_state),   32'd1);
      checkOutput("chg_count",  32'(err_count),   DUTY_ON ? 32'd3 : 32'd2);

      // Invalid ratio
      $display("[TB] invalid ratio");
      cfg_div_ratio = 4'd1;
      err_clr = 1'b1;
      applyStimulus(1);
      err_clr = 1'b0;
      checkOutput("cfg_code",   32'(error_code),  32'h80);
      repeat (2) monPeriod(2, 2);
      checkOutput("cfg_state",  32'(mon_state),   32'd0);
      checkOutput("cfg_locked", 32'(clk_locked),  32'd0);

      // Asynchronous reset in the middle of LOCKED
      $display("[TB] async reset while locked");
      cfg_div_ratio = 4'd4;
      repeat (5) monPeriod(2, 2);
      checkOutput("ars_prelock", 32'(clk_locked), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("ars_state",  32'(mon_state),   32'd0);
      checkOutput("ars_locked", 32'(clk_locked),  32'd0);
      checkOutput("ars_count",  32'(err_count),   32'd0);
      checkOutput("ars_period", 32'(meas_period), 32'd0);
      checkOutput("ars_code",   32'(error_code),  32'h00);
      repeat (2) @(posedge ref_clk);
      #1;
      rst_n = 1'b1;
      vc0 = valid_count;
      repeat (5) monPeriod(2, 2);
      checkOutput("ars_relock", 32'(clk_locked),  32'd1);
      checkOutput("ars_valids", 32'(valid_count - vc0), 32'd4);
      checkOutput("ars_mper",   32'(meas_period), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
